// File: rtl/tage_pkg.sv
// tage_pkg: shared TAGE types, saturating counter helper and table index (TAGE_BASE_HASH_EN selects XOR-hashed index)
package tage_pkg;
  typedef enum logic {INIT, READY} tage_init_state_t;
  function automatic logic [7:0] sat_ctr_update(input logic [7:0] ctr, input logic taken, input int width);
    logic [7:0] max_v;
    max_v = 8'((9'd1 << width) - 9'd1);
    return taken ? ((ctr >= max_v) ? max_v : ctr + 8'd1) : ((ctr == 8'd0) ? 8'd0 : ctr - 8'd1);
  endfunction
  function automatic logic [31:0] tage_index(input logic [31:0] pc, input logic [31:0] ghr, input int index_bits, input int hist_bits, input int pc_shift);
    logic [31:0] pc_bits, ghr_up, idx_mask, pc_mask;
    idx_mask = (32'd1 << index_bits) - 32'd1;
    pc_mask = (32'd1 << (index_bits - hist_bits)) - 32'd1;
    pc_bits = pc >> pc_shift;
    ghr_up = (ghr & ((32'd1 << hist_bits) - 32'd1)) << (index_bits - hist_bits);
`ifdef TAGE_BASE_HASH_EN
    return (pc_bits ^ ghr_up) & idx_mask;
`else
    return ((pc_bits & pc_mask) | ghr_up) & idx_mask;
`endif
  endfunction
endpackage

// File: rtl/dual_port_ram.sv
// dual_port_ram: one write port, one synchronous read port
module dual_port_ram #(
  parameter int num_entries = 1024,
  parameter int addr_width = 10,
  parameter int data_width = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic                  re,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);
  logic [data_width-1:0] mem [num_entries];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/tage_base_table.sv
// tage_base_table: TAGE T0 counter table with init sweep, bypass and optional TAGE_BASE_HASH_EN index hashing
module tage_base_table
  import tage_pkg::*;
#(
  parameter int INDEX_BITS = 10,
  parameter int HIST_BITS = 2,
  parameter int CTR_BITS = 2,
  parameter int PC_SHIFT = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    lookup_valid,
  input  logic [31:0]                             lookup_pc,
  input  logic [(HIST_BITS > 0 ? HIST_BITS : 1)-1:0] lookup_ghr,
  output logic                                    pred_valid,
  output logic [CTR_BITS-1:0]                     pred_ctr,
  output logic                                    pred_taken,
  input  logic                                    update_valid,
  input  logic [31:0]                             update_pc,
  input  logic [(HIST_BITS > 0 ? HIST_BITS : 1)-1:0] update_ghr,
  input  logic                                    update_taken,
  input  logic [CTR_BITS-1:0]                     update_ctr,
  output logic                                    ready
);
  localparam int NUM_ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  tage_init_state_t state, state_nx;
  logic [INDEX_BITS-1:0] sweep, lk_idx, up_idx, waddr;
  logic [CTR_BITS-1:0] up_val, wdata, rdata, byp_val, held;
  logic we, pv, byp;
  assign lk_idx = INDEX_BITS'(tage_index(lookup_pc, 32'(lookup_ghr), INDEX_BITS, HIST_BITS, PC_SHIFT));
  assign up_idx = INDEX_BITS'(tage_index(update_pc, 32'(update_ghr), INDEX_BITS, HIST_BITS, PC_SHIFT));
  assign up_val = CTR_BITS'(sat_ctr_update(8'(update_ctr), update_taken, CTR_BITS));
  assign ready = state == READY;
  always_comb begin
    state_nx = (state == INIT && sweep == '1) ? READY : state;
    we = ready ? update_valid : 1'b1;
    waddr = ready ? up_idx : sweep;
    wdata = ready ? up_val : WEAK_NT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      sweep <= '0;
      pv <= 1'b0;
      byp <= 1'b0;
      byp_val <= '0;
      held <= '0;
    end else begin
      state <= state_nx;
      sweep <= ready ? sweep : sweep + 1'b1;
      pv <= lookup_valid && ready;
      byp <= ready && update_valid && lookup_valid && lk_idx == up_idx;
      byp_val <= up_val;
      if (pv) held <= pred_ctr;
    end
  end
  dual_port_ram #(
    .num_entries(NUM_ENTRIES),
    .addr_width(INDEX_BITS),
    .data_width(CTR_BITS)
  ) u_ram (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .re(lookup_valid && ready),
    .raddr(lk_idx),
    .rdata(rdata)
  );
  assign pred_valid = pv;
  assign pred_ctr = pv ? (byp ? byp_val : rdata) : held;
  assign pred_taken = pred_ctr[CTR_BITS-1];
endmodule

// File: tb/tb_tage_base_table.sv
// tb_tage_base_table: scoreboard bench for tage_base_table (default and 6-bit/3-bit-counter instances)
module tb_tage_base_table;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic lookup_valid = 0, update_valid = 0, update_taken = 0;
  logic [31:0] lookup_pc = 0, update_pc = 0;
  logic [1:0] lookup_ghr = 0, update_ghr = 0, update_ctr = 0, pred_ctr;
  logic pred_valid, pred_taken, ready;
  logic p_lv = 0, p_uv = 0, p_ut = 0, p_pv, p_pt, p_ready;
  logic [31:0] p_lpc = 0, p_upc = 0;
  logic [1:0] p_lghr = 0, p_ughr = 0;
  logic [2:0] p_uctr = 0, p_pctr;
  int checks = 0, passes = 0;
  logic [1:0] q[$];
  logic [1:0] mdl [1024];
  logic [1:0] mon_exp;

  tage_base_table dut (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_ghr(lookup_ghr),
    .pred_valid(pred_valid), .pred_ctr(pred_ctr), .pred_taken(pred_taken), .update_valid(update_valid),
    .update_pc(update_pc), .update_ghr(update_ghr), .update_taken(update_taken), .update_ctr(update_ctr),
    .ready(ready)
  );
  tage_base_table #(.INDEX_BITS(6), .CTR_BITS(3)) p (
    .clk(clk), .rst(rst), .lookup_valid(p_lv), .lookup_pc(p_lpc), .lookup_ghr(p_lghr),
    .pred_valid(p_pv), .pred_ctr(p_pctr), .pred_taken(p_pt), .update_valid(p_uv),
    .update_pc(p_upc), .update_ghr(p_ughr), .update_taken(p_ut), .update_ctr(p_uctr),
    .ready(p_ready)
  );

  function automatic int idx(input logic [31:0] pc, input logic [1:0] g);
`ifdef TAGE_BASE_HASH_EN
    return int'({g, 8'h00} ^ pc[9:0]);
`else
    return int'({g, pc[7:0]});
`endif
  endfunction

  function automatic logic [1:0] nxt(input logic [1:0] c, input logic t);
    return t ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
  endfunction

  always @(negedge clk) begin
    if (!rst && pred_valid) begin
      checks++;
      if (q.size() == 0) $display("FAIL scoreboard: unexpected pred_valid, pred_ctr=%b", pred_ctr);
      else begin
        mon_exp = q.pop_front();
        if (pred_ctr !== mon_exp || pred_taken !== mon_exp[1])
          $display("FAIL pred_ctr: got ctr=%b taken=%b, expected ctr=%b taken=%b", pred_ctr, pred_taken, mon_exp, mon_exp[1]);
        else passes++;
      end
    end
  end

  task automatic drive(input logic lv, input logic [31:0] lpc, input logic [1:0] lg, input logic uv,
                       input logic [31:0] upc, input logic [1:0] ug, input logic [1:0] uc, input logic ut);
    lookup_valid = lv; lookup_pc = lpc; lookup_ghr = lg;
    update_valid = uv; update_pc = upc; update_ghr = ug; update_ctr = uc; update_taken = ut;
    if (lv) q.push_back((uv && idx(upc, ug) == idx(lpc, lg)) ? nxt(uc, ut) : mdl[idx(lpc, lg)]);
    if (uv) mdl[idx(upc, ug)] = nxt(uc, ut);
    @(posedge clk); #1;
    lookup_valid = 0; update_valid = 0;
  endtask

  task automatic sweep_wait(input int inj_k, input logic [31:0] inj_pc, output int rdy_at, output int p_rdy_at);
    rdy_at = 0; p_rdy_at = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk); #1;
      if (ready && rdy_at == 0) rdy_at = k;
      if (p_ready && p_rdy_at == 0) p_rdy_at = k;
      lookup_valid = (k == inj_k); update_valid = (k == inj_k);
      lookup_pc = inj_pc; lookup_ghr = 0; update_pc = inj_pc; update_ghr = 0; update_ctr = 2'b11; update_taken = 1;
    end
    lookup_valid = 0; update_valid = 0;
    foreach (mdl[i]) mdl[i] = 2'b01;
  endtask

  task automatic test_reset;
    int r, pr;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pred_valid !== 1'b0) $display("FAIL reset pred_valid: got %b want 0", pred_valid); else passes++;
    checks++; if (pred_ctr !== 2'b00) $display("FAIL reset pred_ctr: got %b want 00", pred_ctr); else passes++;
    checks++; if (pred_taken !== 1'b0) $display("FAIL reset pred_taken: got %b want 0", pred_taken); else passes++;
    checks++; if (ready !== 1'b0) $display("FAIL reset ready: got %b want 0", ready); else passes++;
    rst = 0;
    sweep_wait(600, 32'h5, r, pr);
    checks++; if (r !== 1024) $display("FAIL sweep ready cycle: got %0d want 1024", r); else passes++;
    checks++; if (pr !== 64) $display("FAIL param sweep ready cycle: got %0d want 64", pr); else passes++;
  endtask

  task automatic test_init_values;
    drive(1, 32'h0, 2'b00, 0, 0, 0, 0, 0);
    drive(1, 32'h5, 2'b00, 0, 0, 0, 0, 0);
    drive(1, 32'hff, 2'b11, 0, 0, 0, 0, 0);
    drive(1, 32'h1234_5678, 2'b01, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk); #1;
    checks++; if (q.size() != 0) $display("FAIL init drain: %0d predictions missing, want 0", q.size()); else passes++;
  endtask

  task automatic test_saturation;
    drive(0, 0, 0, 1, 32'h20, 2'b00, 2'b11, 1);
    drive(0, 0, 0, 1, 32'h21, 2'b00, 2'b00, 0);
    drive(0, 0, 0, 1, 32'h22, 2'b00, 2'b01, 1);
    drive(1, 32'h20, 2'b00, 0, 0, 0, 0, 0);
    drive(1, 32'h21, 2'b00, 0, 0, 0, 0, 0);
    drive(1, 32'h22, 2'b00, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk); #1;
    checks++; if (q.size() != 0) $display("FAIL saturation drain: %0d predictions missing, want 0", q.size()); else passes++;
  endtask

  task automatic test_bypass;
    drive(1, 32'h40, 2'b10, 1, 32'h40, 2'b10, 2'b01, 1);
    drive(1, 32'h40, 2'b10, 0, 0, 0, 0, 0);
    drive(1, 32'h50, 2'b00, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h50, 2'b00, 2'b11, 1);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (q.size() != 0) $display("FAIL bypass drain: %0d predictions missing, want 0", q.size()); else passes++;
    checks++;
    if (pred_valid !== 1'b0 || pred_ctr !== 2'b01) $display("FAIL hold: got valid=%b ctr=%b want valid=0 ctr=01", pred_valid, pred_ctr);
    else passes++;
  endtask

  task automatic test_aliasing;
    drive(0, 0, 0, 1, 32'h10, 2'b11, 2'b11, 1);
    drive(1, 32'h10, 2'b00, 0, 0, 0, 0, 0);
    drive(1, 32'h10, 2'b11, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk); #1;
    checks++; if (q.size() != 0) $display("FAIL aliasing drain: %0d predictions missing, want 0", q.size()); else passes++;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    @(posedge clk); @(negedge clk); #1;
    checks++; if (q.size() != 0) $display("FAIL back_to_back drain: %0d predictions missing, want 0", q.size()); else passes++;
  endtask

  task automatic test_mid_reset;
    int r, pr;
    rst = 1; @(posedge clk); #1; rst = 0;
    repeat (500) @(posedge clk);
    #1; rst = 1;
    repeat (2) @(posedge clk);
    #1; rst = 0;
    sweep_wait(700, 32'h22, r, pr);
    checks++; if (r !== 1024) $display("FAIL mid-reset ready cycle: got %0d want 1024", r); else passes++;
    checks++; if (pr !== 64) $display("FAIL mid-reset param ready cycle: got %0d want 64", pr); else passes++;
    drive(1, 32'h22, 2'b00, 0, 0, 0, 0, 0);
    drive(1, 32'h20, 2'b00, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk); #1;
    checks++; if (q.size() != 0) $display("FAIL mid-reset drain: %0d predictions missing, want 0", q.size()); else passes++;
  endtask

  task automatic test_param;
    logic [2:0] uc [4] = '{3'd0, 3'd7, 3'd0, 3'd3};
    logic ut [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] ex [4] = '{3'b011, 3'b111, 3'b000, 3'b100};
    for (int i = 0; i < 4; i++) begin
      p_uv = (i != 0); p_upc = 32'(i); p_ughr = 2'b01; p_uctr = uc[i]; p_ut = ut[i];
      @(posedge clk); #1;
      p_uv = 0; p_lv = 1; p_lpc = 32'(i); p_lghr = 2'b01;
      @(posedge clk); #1;
      p_lv = 0;
      checks++;
      if (p_pv !== 1'b1 || p_pctr !== ex[i] || p_pt !== ex[i][2])
        $display("FAIL param entry %0d: got valid=%b ctr=%b taken=%b want 1 %b %b", i, p_pv, p_pctr, p_pt, ex[i], ex[i][2]);
      else passes++;
    end
  endtask

  initial begin
    test_reset;
    test_init_values;
    test_saturation;
    test_bypass;
    test_aliasing;
    test_back_to_back;
    test_mid_reset;
    test_param;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
